cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for `simple_cpu`. It fetches 20-bit instructions from instruction memory over a valid handshake and holds them in an instruction register. It decodes the opcode and steps the datapath through FETCH/DECODE/EXEC/MEM/WB, driving register-file, ALU and data-memory strobes. It replaces the bench-driven `instruction` bus: the CPU datapath consumes `ir` and the control strobes from this block.

## Interface
- `DATA_WIDTH`, 8, datapath width (passed through for package consistency)
- `ADDR_BITS`, 5, data-memory address bits
- `INSTR_WIDTH`, 20, instruction width; field positions below assume 20
- `PC_BITS`, 5, program-counter / instruction-memory address bits
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `start`  in  1  begin execution from PC 0; honoured only in IDLE
- `instr_req`  out  1  instruction fetch request
- `instr_addr`  out  PC_BITS  fetch address (= PC)
- `instr_valid`  in  1  `instr_data` valid this cycle
- `instr_data`  in  INSTR_WIDTH  fetched instruction
- `ir`  out  INSTR_WIDTH  latched instruction to datapath
- `rf_re`  out  1  register-file read strobe
- `rf_we`  out  1  register-file write strobe
- `alu_sub`  out  1  0 = ADD, 1 = SUB
- `dmem_re` / `dmem_we`  out  1  data-memory read / write request
- `dmem_ack`  in  1  data-memory transfer complete
- `busy`  out  1  high in any state except IDLE and HALT
- `halted`  out  1  high in HALT
- `retired`  out  1  one-cycle pulse per completed instruction
- `retire_cnt`  out  8  retired-instruction count, wraps at 255
- `step`  in  1  present only with `CPU_SEQ_SINGLE_STEP_EN`

## Operation
- Fields:
  - `op = ir[19:18]`
  - `X1 = ir[17:16]`, `X2 = ir[15:14]`, `X3 = ir[13:12]`
  - `offset = ir[11:4]`
  - `func = ir[0]`
- Opcodes: 00 HALT, 01 ALU (`func`: 0 ADD, 1 SUB), 10 LOAD_R, 11 STORE_R.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT (plus PAUSE when the macro is set).
- IDLE: `start` = 1 → FETCH.
- FETCH:
  - `instr_req` = 1 and `instr_addr` = PC, held stable until `instr_valid`.
  - On `instr_valid`: `ir` ← `instr_data`, PC ← PC+1 (wraps modulo 2^PC_BITS) → DECODE.
- DECODE:
  - `rf_re` = 1 for one cycle.
  - op 00 → HALT; otherwise → EXEC.
- EXEC:
  - ALU: `alu_sub` = `func` → WB.
  - LOAD_R/STORE_R: address phase (datapath forms `X2 + offset`, truncated to ADDR_BITS) → MEM.
- MEM:
  - `dmem_re` (LOAD_R) or `dmem_we` (STORE_R) held high until `dmem_ack`.
  - LOAD_R + ack → WB.
  - STORE_R + ack → `retired` pulse → FETCH.
- WB: `rf_we` = 1 for one cycle, `retired` pulse → FETCH.
- HALT: sticky until reset; `start` is ignored.
- `start` outside IDLE is ignored.
- `retire_cnt` increments on every `retired` pulse.
- `dmem_ack` outside MEM and `instr_valid` outside FETCH are ignored.

## Timing
- Reset values: state IDLE, PC 0, `ir` 0, `retire_cnt` 0, all strobes and flags 0.
- Reset mid-transaction abandons the request; outputs drop asynchronously.
- Latency with zero wait states (`instr_valid` and `dmem_ack` high on first request cycle), counted from FETCH entry to next FETCH entry:
  - ALU and STORE_R: 4 cycles.
  - LOAD_R: 5 cycles.
- Each wait cycle on `instr_valid` or `dmem_ack` adds exactly one cycle.
- `alu_sub` is valid during EXEC and WB and is 0 elsewhere.
- Strobes are registered Moore outputs: no combinational path from any input to any output.

## Configuration
- Macro: `CPU_SEQ_SINGLE_STEP_EN`.
- Defined:
  - The `step` port exists.
  - After each retire the FSM enters PAUSE instead of FETCH.
  - A `step` pulse moves PAUSE → FETCH.
  - `busy` = 0 in PAUSE.
- Undefined: no `step` port, no PAUSE state; instructions run back-to-back.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (OP_HALT, OP_ALU, OP_LOAD, OP_STORE)
  - the state enum typedef
  - field bit-position constants
  - the default parameter values
- One sub-module, `cpu_decode`: a combinational opcode/func decoder producing `is_alu`, `is_load`, `is_store`, `is_halt`, `alu_sub`.

## Test plan
- Reset, then `start`; memory returns `20'b01000111000000000000` with immediate valid → `rf_re` in DECODE, `rf_we` 2 cycles later, `retired` at cycle 4, PC = 1, `alu_sub` = 0.
- Instruction `20'b01110010000000000001` → `alu_sub` = 1 in EXEC/WB; `retire_cnt` increments.
- STORE_R `20'b11011000000011110000` with `dmem_ack` delayed 3 cycles → `dmem_we` high for 4 cycles, no `rf_we`, total 7 cycles.
- LOAD_R `20'b10111000000011110000` with immediate ack → `dmem_re` 1 cycle, `rf_we` 1 cycle, 5 cycles total.
- Opcode 00 → `halted` = 1, `busy` = 0; later `start` ignored; `rst` = 0 mid-MEM clears everything instantly.
- PC at 31 fetches → PC wraps to 0; with `CPU_SEQ_SINGLE_STEP_EN`, no FETCH until `step` pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the simple_cpu control path: default parameter
// values, opcode encodings, instruction field bit positions and the
// sequencer state enum.
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN adds the PAUSE state.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Default parameter values
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_BITS   = 5;
  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 5;

  // Opcodes (ir[OP_HI:OP_LO])
  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  // Field bit positions for a 20-bit instruction word
  localparam int OP_HI    = 19;
  localparam int OP_LO    = 18;
  localparam int X1_HI    = 17;
  localparam int X1_LO    = 16;
  localparam int X2_HI    = 15;
  localparam int X2_LO    = 14;
  localparam int X3_HI    = 13;
  localparam int X3_LO    = 12;
  localparam int OFF_HI   = 11;
  localparam int OFF_LO   = 4;
  localparam int FUNC_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
`ifdef CPU_SEQ_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
// Instruction-fetch and data-memory handshake bundle between the sequencer
// and the memories.
//   master : sequencer side  (drives instr_req/instr_addr, dmem_re/dmem_we)
//   slave  : memory side     (drives instr_valid/instr_data, dmem_ack)
// -----------------------------------------------------------------------------
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = DEF_PC_BITS
) ();

  logic                   instr_req;
  logic [PC_BITS-1:0]     instr_addr;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic                   dmem_re;
  logic                   dmem_we;
  logic                   dmem_ack;

  modport master (
    output instr_req, instr_addr, dmem_re, dmem_we,
    input  instr_valid, instr_data, dmem_ack
  );

  modport slave (
    input  instr_req, instr_addr, dmem_re, dmem_we,
    output instr_valid, instr_data, dmem_ack
  );

endinterface

// File: rtl/cpu_decode.sv
// -----------------------------------------------------------------------------
// cpu_decode
// Combinational opcode/func decoder.
//   op      : instruction opcode field
//   func    : ALU function bit (0 ADD, 1 SUB)
//   is_*    : one-hot instruction class
//   alu_sub : subtract request, only meaningful for ALU instructions
// -----------------------------------------------------------------------------
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [1:0] op,
  input  logic       func,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_halt,
  output logic       alu_sub
);

  assign is_halt  = (op == OP_HALT);
  assign is_alu   = (op == OP_ALU);
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  // Address formation for LOAD/STORE is always an add.
  assign alu_sub  = is_alu & func;

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer for simple_cpu: fetches instructions into
// ir and walks FETCH/DECODE/EXEC/MEM/WB, issuing register-file, ALU and
// data-memory strobes. All outputs are registered (Moore).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : leave IDLE and fetch from PC 0
//   step              : PAUSE -> FETCH (only with CPU_SEQ_SINGLE_STEP_EN)
//   bus (master)      : instruction fetch and data-memory handshakes
//   ir                : latched instruction for the datapath
//   rf_re, rf_we      : register-file read / write strobes
//   alu_sub           : 0 ADD, 1 SUB (valid in EXEC and WB)
//   busy, halted      : activity / sticky halt flags
//   retired           : one-cycle pulse per completed instruction
//   retire_cnt        : wrapping retired-instruction count
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN (pause after each retire).
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = DEF_PC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                   step,
`endif
  cpu_sequencer_if.master        bus,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   rf_re,
  output logic                   rf_we,
  output logic                   alu_sub,
  output logic                   busy,
  output logic                   halted,
  output logic                   retired,
  output logic [7:0]             retire_cnt
);

  // Where the FSM goes once an instruction retires.
`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam seq_state_t AFTER_RETIRE = ST_PAUSE;
  localparam logic       AFTER_REQ    = 1'b0;
`else
  localparam seq_state_t AFTER_RETIRE = ST_FETCH;
  localparam logic       AFTER_REQ    = 1'b1;
`endif

  seq_state_t         state;
  logic [PC_BITS-1:0] pc;
  logic               is_alu, is_load, is_store, is_halt, dec_alu_sub;

  cpu_decode u_decode (
    .op       (ir[OP_HI:OP_LO]),
    .func     (ir[FUNC_BIT]),
    .is_alu   (is_alu),
    .is_load  (is_load),
    .is_store (is_store),
    .is_halt  (is_halt),
    .alu_sub  (dec_alu_sub)
  );

  assign bus.instr_addr = pc;

  // Outputs are written on the transition into the state that owns them,
  // so each strobe is a flop that is high exactly while in that state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      pc            <= '0;
      ir            <= '0;
      bus.instr_req <= 1'b0;
      bus.dmem_re   <= 1'b0;
      bus.dmem_we   <= 1'b0;
      rf_re         <= 1'b0;
      rf_we         <= 1'b0;
      alu_sub       <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      retired       <= 1'b0;
      retire_cnt    <= '0;
    end else begin
      // NOTE: retired defaults low each cycle and is only set on the edge
      // that completes an instruction, giving a single-cycle pulse.
      retired <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_FETCH;
            pc            <= '0;
            bus.instr_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.instr_valid) begin
            state         <= ST_DECODE;
            ir            <= bus.instr_data;
            pc            <= pc + PC_BITS'(1);
            bus.instr_req <= 1'b0;
            rf_re         <= 1'b1;
          end
        end
        ST_DECODE: begin
          rf_re <= 1'b0;
          if (is_halt) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state   <= ST_EXEC;
            alu_sub <= dec_alu_sub;
          end
        end
        ST_EXEC: begin
          if (is_alu) begin
            state      <= ST_WB;
            rf_we      <= 1'b1;
            retired    <= 1'b1;
            retire_cnt <= retire_cnt + 8'd1;
          end else begin
            state       <= ST_MEM;
            bus.dmem_re <= is_load;
            bus.dmem_we <= is_store;
          end
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_re <= 1'b0;
            bus.dmem_we <= 1'b0;
            retired     <= 1'b1;
            retire_cnt  <= retire_cnt + 8'd1;
            if (is_load) begin
              state <= ST_WB;
              rf_we <= 1'b1;
            end else begin
              state         <= AFTER_RETIRE;
              bus.instr_req <= AFTER_REQ;
              busy          <= AFTER_REQ;
            end
          end
        end
        ST_WB: begin
          state         <= AFTER_RETIRE;
          rf_we         <= 1'b0;
          alu_sub       <= 1'b0;
          bus.instr_req <= AFTER_REQ;
          busy          <= AFTER_REQ;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
`ifdef CPU_SEQ_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (step) begin
            state         <= ST_FETCH;
            bus.instr_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer. The bench plays instruction and
// data memory with programmable wait states and compares each instruction's
// observable behaviour (latency, strobe counts, strobe timing, PC, retire
// count) against expectations computed from the instruction class.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int IW = DEF_INSTR_WIDTH;
  localparam int PB = DEF_PC_BITS;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam int PAUSE_CYC = 1;
`else
  localparam int PAUSE_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] ir;
  logic          rf_re, rf_we, alu_sub, busy, halted, retired;
  logic [7:0]    retire_cnt;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic          step = 1'b1;
`endif

  cpu_sequencer_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus ();

  cpu_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .bus        (bus),
    .ir         (ir),
    .rf_re      (rf_re),
    .rf_we      (rf_we),
    .alu_sub    (alu_sub),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_pc = 0;
  int model_retired = 0;
  int tally_retired = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its FETCH entry to the next FETCH entry (or
  // HALT), with fw fetch wait cycles and aw data-memory wait cycles.
  task automatic run_instr(input logic [IW-1:0] instr, input int fw, input int aw,
                           input bit start_noise);
    logic [1:0] op;
    bit is_alu, is_ld, is_st, is_hl, sub;
    bit fetched;
    int guard, cycles, fcnt, mcnt;
    int n_rfre, n_rfwe, n_dre, n_dwe, n_sub, busy_low, rfre_at, rfwe_at, ret_at;
    int exp_cycles;

    op     = instr[OP_HI:OP_LO];
    is_alu = (op == 2'b01);
    is_ld  = (op == 2'b10);
    is_st  = (op == 2'b11);
    is_hl  = (op == 2'b00);
    sub    = is_alu && instr[0];
    fetched = 1'b0;
    cycles = 0; fcnt = 0; mcnt = 0;
    n_rfre = 0; n_rfwe = 0; n_dre = 0; n_dwe = 0; n_sub = 0; busy_low = 0;
    rfre_at = 0; rfwe_at = 0; ret_at = 0;

    guard = 0;
    while (!bus.instr_req && guard < 20) begin
      tick();
      guard++;
    end
    check("fetch_req", bus.instr_req, 1);
    check("instr_addr", bus.instr_addr, model_pc);

    while (cycles < 60) begin
      cycles++;
      if (retired) begin
        tally_retired++;
        if (cycles > 1 && ret_at == 0) ret_at = cycles;
      end
      if (rf_re) begin n_rfre++; if (rfre_at == 0) rfre_at = cycles; end
      if (rf_we) begin n_rfwe++; if (rfwe_at == 0) rfwe_at = cycles; end
      if (bus.dmem_re) n_dre++;
      if (bus.dmem_we) n_dwe++;
      if (alu_sub) n_sub++;
      if (!busy) busy_low++;

      // Memory responses for the coming edge; noise where it must be ignored.
      if (bus.instr_req) begin
        bus.instr_valid = (fcnt == fw);
        fcnt++;
      end else begin
        bus.instr_valid = 1'($urandom_range(0, 1));
      end
      if (bus.instr_req && bus.instr_valid) fetched = 1'b1;
      bus.instr_data = (bus.instr_req && bus.instr_valid) ? instr : IW'($urandom);
      if (bus.dmem_re || bus.dmem_we) begin
        bus.dmem_ack = (mcnt == aw);
        mcnt++;
      end else begin
        bus.dmem_ack = 1'($urandom_range(0, 1));
      end
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;

      tick();
      if (fetched && (bus.instr_req || halted)) break;
    end
    bus.instr_valid = 1'b0;
    bus.dmem_ack    = 1'b0;
    start           = 1'b0;

    if (is_hl)       exp_cycles = 2 + fw;
    else if (is_ld)  exp_cycles = 5 + fw + aw + PAUSE_CYC;
    else if (is_st)  exp_cycles = 4 + fw + aw + PAUSE_CYC;
    else             exp_cycles = 4 + fw + PAUSE_CYC;
    model_pc = (model_pc + 1) % (1 << PB);
    if (!is_hl) model_retired++;

    check("latency", cycles, exp_cycles);
    check("ir", ir, instr);
    check("rf_re_cycles", n_rfre, 1);
    check("rf_re_at", rfre_at, 2 + fw);
    check("rf_we_cycles", n_rfwe, (is_alu || is_ld) ? 1 : 0);
    check("rf_we_at", rfwe_at, is_alu ? 4 + fw : (is_ld ? 5 + fw + aw : 0));
    check("dmem_re_cycles", n_dre, is_ld ? 1 + aw : 0);
    check("dmem_we_cycles", n_dwe, is_st ? 1 + aw : 0);
    check("alu_sub_cycles", n_sub, sub ? 2 : 0);
    check("busy_low_cycles", busy_low, is_hl ? 0 : PAUSE_CYC);
    check("halted", halted, is_hl);
    check("retire_cnt", retire_cnt, model_retired % 256);
`ifndef CPU_SEQ_SINGLE_STEP_EN
    check("retired_at", ret_at, is_alu ? 4 + fw : (is_ld ? 5 + fw + aw : 0));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_req"}, bus.instr_req, 0);
    check({tag, "_instr_addr"}, bus.instr_addr, 0);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_rf_re"}, rf_re, 0);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_alu_sub"}, alu_sub, 0);
    check({tag, "_dmem_re"}, bus.dmem_re, 0);
    check({tag, "_dmem_we"}, bus.dmem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_retire_cnt"}, retire_cnt, 0);
  endtask

  initial begin
    logic [IW-1:0] instr;
    int guard;

    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.dmem_ack    = 1'b0;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();
    check("idle_no_start_req", bus.instr_req, 0);

    start = 1'b1;
    tick();
    start = 1'b0;

    // Directed instructions
    run_instr(20'b01000111000000000000, 0, 0, 1'b0);  // ADD
    run_instr(20'b01110010000000000001, 0, 0, 1'b0);  // SUB
    run_instr(20'b11011000000011110000, 0, 3, 1'b0);  // STORE, ack after 3 waits
    run_instr(20'b10111000000011110000, 0, 0, 1'b0);  // LOAD, immediate ack

    // Random non-halt instructions; enough to wrap the PC past 31
    for (int i = 0; i < 36; i++) begin
      instr = IW'($urandom);
      instr[OP_HI:OP_LO] = 2'($urandom_range(1, 3));
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    // HALT is sticky and start is ignored
    instr = IW'($urandom);
    instr[OP_HI:OP_LO] = 2'b00;
    run_instr(instr, 1, 0, 1'b0);
    check("halt_busy", busy, 0);
    check("retired_pulses", tally_retired, model_retired);
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    tick();
    check("halt_sticky", halted, 1);
    check("halt_no_fetch", bus.instr_req, 0);
    check("halt_busy_after_start", busy, 0);
    check("halt_retire_cnt", retire_cnt, model_retired % 256);

    // Reset mid-MEM drops everything without a clock edge
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_pc = 0;
    model_retired = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(20'b01000000000000000000, 0, 0, 1'b0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 20'b10010000000000010000;
    tick();
    bus.instr_valid = 1'b0;
    guard = 0;
    while (!bus.dmem_re && guard < 10) begin
      tick();
      guard++;
    end
    check("reach_mem", bus.dmem_re, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b1;
    model_pc = 0;
    model_retired = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(20'b01000111000000000001, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
